// File: rtl/clk_tick_gen.sv
// Purpose : qualifies the CCC lock, stretches a synchronous fabric reset, and emits us/ms/s ticks plus a ms uptime count.
// Latency : lock_s trails LOCK by 2 edges; RST_OUT falls/READY rises 2+LOCK_FILTER+RST_STRETCH edges after LOCK goes high.
// Backpr. : none -- free-running timebase, no flow control; consumers simply sample the single-cycle ticks.
//
// Ports:
//   CLK, RESET (sync, active-high), LOCK (async CCC lock), SOFT_RST (re-run stretch), LOCK_LOST_CLR
//   RST_OUT / READY (complementary, registered), TICK_US / TICK_MS / TICK_S (1-cycle pulses),
//   LOCK_LOST (sticky), UPTIME_MS (ms spent in RUN, wraps silently)
// Parameter constraints: CLK_HZ/1e6 integer >= 2, LOCK_FILTER >= 1, RST_STRETCH >= 1.

module clk_tick_gen #(
    parameter int CLK_HZ      = 100000000,
    parameter int LOCK_FILTER = 16,
    parameter int RST_STRETCH = 256,
    parameter int US_PER_MS   = 1000,
    parameter int MS_PER_S    = 1000
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        LOCK,
    input  logic        SOFT_RST,
    input  logic        LOCK_LOST_CLR,
    output logic        RST_OUT,
    output logic        READY,
    output logic        TICK_US,
    output logic        TICK_MS,
    output logic        TICK_S,
    output logic        LOCK_LOST,
    output logic [31:0] UPTIME_MS
);

    localparam int US_DIV = CLK_HZ / 1000000;
    localparam int PH_MAX = (LOCK_FILTER > RST_STRETCH) ? LOCK_FILTER : RST_STRETCH;
    localparam int PH_W   = $clog2(PH_MAX + 1);
    localparam int US_W   = $clog2(US_DIV);
    localparam int MS_W   = $clog2(US_PER_MS + 1);
    localparam int S_W    = $clog2(MS_PER_S + 1);

    localparam logic [PH_W-1:0] FILT_LAST = PH_W'(LOCK_FILTER - 1);
    localparam logic [PH_W-1:0] STR_LAST  = PH_W'(RST_STRETCH - 1);
    localparam logic [PH_W-1:0] PH_ONE    = PH_W'(1);
    localparam logic [US_W-1:0] US_LAST   = US_W'(US_DIV - 1);
    localparam logic [US_W-1:0] US_ONE    = US_W'(1);
    localparam logic [MS_W-1:0] MS_LAST   = MS_W'(US_PER_MS - 1);
    localparam logic [MS_W-1:0] MS_ONE    = MS_W'(1);
    localparam logic [S_W-1:0]  S_LAST    = S_W'(MS_PER_S - 1);
    localparam logic [S_W-1:0]  S_ONE     = S_W'(1);

    localparam logic [1:0] ST_WAIT_LOCK = 2'd0;
    localparam logic [1:0] ST_FILTER    = 2'd1;
    localparam logic [1:0] ST_STRETCH   = 2'd2;
    localparam logic [1:0] ST_RUN       = 2'd3;

    logic            lock_meta;
    logic            lock_s;
    logic [1:0]      state_q;
    logic [1:0]      state_nxt;
    logic [PH_W-1:0] ph_q;
    logic [PH_W-1:0] ph_nxt;
    logic            lost_set;
    logic            run_nxt;
    logic [US_W-1:0] us_q;
    logic [MS_W-1:0] ms_q;
    logic [S_W-1:0]  s_q;
    logic            us_wrap;
    logic            ms_wrap;
    logic            s_wrap;
    logic [31:0]     uptime_q;

    // ph_q is shared: it counts qualified lock cycles in FILTER and reset cycles in STRETCH.
    always_comb begin
        state_nxt = state_q;
        ph_nxt    = ph_q;
        lost_set  = 1'b0;
        case (state_q)
            ST_WAIT_LOCK: begin
                ph_nxt = '0;
                if (lock_s) begin
                    state_nxt = ST_FILTER;
                end
            end
            ST_FILTER: begin
                // A dropout here is just an unqualified lock, not a loss.
                if (!lock_s) begin
                    state_nxt = ST_WAIT_LOCK;
                    ph_nxt    = '0;
                end else if (ph_q == FILT_LAST) begin
                    state_nxt = ST_STRETCH;
                    ph_nxt    = '0;
                end else begin
                    ph_nxt = ph_q + PH_ONE;
                end
            end
            ST_STRETCH: begin
                if (!lock_s) begin
                    state_nxt = ST_WAIT_LOCK;
                    ph_nxt    = '0;
                    lost_set  = 1'b1;
                end else if (ph_q == STR_LAST) begin
                    state_nxt = ST_RUN;
                    ph_nxt    = '0;
                end else begin
                    ph_nxt = ph_q + PH_ONE;
                end
            end
            ST_RUN: begin
                ph_nxt = '0;
                // Lock loss is checked first so it beats a simultaneous SOFT_RST.
                if (!lock_s) begin
                    state_nxt = ST_WAIT_LOCK;
                    lost_set  = 1'b1;
                end else if (SOFT_RST) begin
                    state_nxt = ST_STRETCH;
                end
            end
            default: begin
                state_nxt = ST_WAIT_LOCK;
                ph_nxt    = '0;
            end
        endcase
    end

    // Everything downstream keys off the next state so that outputs and ticks
    // change on the very edge the FSM moves.
    assign run_nxt = (state_nxt == ST_RUN);
    assign us_wrap = (us_q == US_LAST);
    assign ms_wrap = us_wrap && (ms_q == MS_LAST);
    assign s_wrap  = ms_wrap && (s_q == S_LAST);

    always_ff @(posedge CLK) begin
        if (RESET) begin
            lock_meta <= 1'b0;
            lock_s    <= 1'b0;
            state_q   <= ST_WAIT_LOCK;
            ph_q      <= '0;
            RST_OUT   <= 1'b1;
            READY     <= 1'b0;
            us_q      <= '0;
            ms_q      <= '0;
            s_q       <= '0;
            TICK_US   <= 1'b0;
            TICK_MS   <= 1'b0;
            TICK_S    <= 1'b0;
            LOCK_LOST <= 1'b0;
            uptime_q  <= '0;
        end else begin
            lock_meta <= LOCK;
            lock_s    <= lock_meta;
            state_q   <= state_nxt;
            ph_q      <= ph_nxt;
            RST_OUT   <= !run_nxt;
            READY     <= run_nxt;

            if (run_nxt) begin
                us_q <= us_wrap ? '0 : us_q + US_ONE;
                if (us_wrap) begin
                    ms_q <= ms_wrap ? '0 : ms_q + MS_ONE;
                end
                if (ms_wrap) begin
                    s_q      <= s_wrap ? '0 : s_q + S_ONE;
                    uptime_q <= uptime_q + 32'd1;
                end
                TICK_US <= us_wrap;
                TICK_MS <= ms_wrap;
                TICK_S  <= s_wrap;
            end else begin
                // Leaving RUN restarts the tick phase; uptime simply holds.
                us_q    <= '0;
                ms_q    <= '0;
                s_q     <= '0;
                TICK_US <= 1'b0;
                TICK_MS <= 1'b0;
                TICK_S  <= 1'b0;
            end

            // Set has priority over a same-cycle clear.
            if (lost_set) begin
                LOCK_LOST <= 1'b1;
            end else if (LOCK_LOST_CLR) begin
                LOCK_LOST <= 1'b0;
            end
        end
    end

    assign UPTIME_MS = uptime_q;

endmodule

// File: tb/tb_clk_tick_gen.sv
// Bench for clk_tick_gen: expectations are queued with the edge they apply to
// and checked by a monitor shortly after that edge.

module tb_clk_tick_gen;

    localparam int S_RST  = 0;
    localparam int S_RDY  = 1;
    localparam int S_LOST = 2;
    localparam int S_TUS  = 3;
    localparam int S_TMS  = 4;
    localparam int S_TS   = 5;
    localparam int S_UPT  = 6;

    typedef struct {
        int          at;
        int          sig;
        logic [31:0] val;
        string       name;
    } exp_t;

    typedef struct {
        int          rel;
        int          sig;
        logic [31:0] val;
        string       name;
    } vec_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        lock = 1'b0;
    logic        soft_rst = 1'b0;
    logic        lock_lost_clr = 1'b0;
    logic        rst_out;
    logic        ready;
    logic        tick_us;
    logic        tick_ms;
    logic        tick_s;
    logic        lock_lost;
    logic [31:0] uptime_ms;

    int   cyc = 0;
    int   n_vec = 0;
    int   n_bad = 0;
    exp_t sb[$];

    clk_tick_gen #(
        .CLK_HZ      (4000000),
        .LOCK_FILTER (4),
        .RST_STRETCH (8),
        .US_PER_MS   (10),
        .MS_PER_S    (10)
    ) dut (
        .CLK           (clk),
        .RESET         (reset),
        .LOCK          (lock),
        .SOFT_RST      (soft_rst),
        .LOCK_LOST_CLR (lock_lost_clr),
        .RST_OUT       (rst_out),
        .READY         (ready),
        .TICK_US       (tick_us),
        .TICK_MS       (tick_ms),
        .TICK_S        (tick_s),
        .LOCK_LOST     (lock_lost),
        .UPTIME_MS     (uptime_ms)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (edge %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [31:0] sig_val(input int s);
        case (s)
            S_RST:   return {31'd0, rst_out};
            S_RDY:   return {31'd0, ready};
            S_LOST:  return {31'd0, lock_lost};
            S_TUS:   return {31'd0, tick_us};
            S_TMS:   return {31'd0, tick_ms};
            S_TS:    return {31'd0, tick_s};
            default: return uptime_ms;
        endcase
    endfunction

    function automatic vec_t mkv(input int rel, input int sig, input logic [31:0] val, input string name);
        vec_t v;
        v.rel = rel; v.sig = sig; v.val = val; v.name = name;
        return v;
    endfunction

    // Queue an expectation for the value seen just after edge 'at', keeping the queue in edge order.
    task automatic ex(input int at, input int sig, input logic [31:0] val, input string name);
        exp_t e;
        int   i;
        e.at = at; e.sig = sig; e.val = val; e.name = name;
        i = 0;
        while (i < sb.size() && sb[i].at <= at) i++;
        sb.insert(i, e);
    endtask

    // Park on the negedge just before edge e, so inputs driven now are sampled at e.
    task automatic goto_edge(input int e);
        if (cyc > e - 1) chk("schedule", 32'(cyc), 32'(e - 1));
        while (cyc < e - 1) @(negedge clk);
    endtask

    task automatic do_reset(input string tag, output int t0);
        @(negedge clk);
        reset = 1'b1; lock = 1'b0; soft_rst = 1'b0; lock_lost_clr = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk({tag, "_rst_out"},   {31'd0, rst_out},   32'd1);
        chk({tag, "_ready"},     {31'd0, ready},     32'd0);
        chk({tag, "_tick_us"},   {31'd0, tick_us},   32'd0);
        chk({tag, "_tick_ms"},   {31'd0, tick_ms},   32'd0);
        chk({tag, "_tick_s"},    {31'd0, tick_s},    32'd0);
        chk({tag, "_lock_lost"}, {31'd0, lock_lost}, 32'd0);
        chk({tag, "_uptime"},    uptime_ms,          32'd0);
        @(negedge clk);
        reset = 1'b0; lock = 1'b1;
        t0 = cyc + 1;
    endtask

    always begin : mon
        exp_t e;
        @(posedge clk);
        #1;
        while (sb.size() != 0 && sb[0].at <= cyc) begin
            e = sb.pop_front();
            if (e.at < cyc) chk({e.name, "_missed"}, 32'(cyc), 32'(e.at));
            else            chk(e.name, sig_val(e.sig), e.val);
        end
    end

    initial begin
        vec_t pu[14];
        int   t0, d, r, c, d2, r2, e0, s, f, g;
        int   n_us, n_ms, n_s, n_rdy_lo, n_align, last_us;

        pu[0]  = mkv(13,  S_RST,  32'd1, "pu_rst_e13");
        pu[1]  = mkv(13,  S_RDY,  32'd0, "pu_ready_e13");
        pu[2]  = mkv(14,  S_RST,  32'd0, "pu_rst_e14");
        pu[3]  = mkv(14,  S_RDY,  32'd1, "pu_ready_e14");
        pu[4]  = mkv(14,  S_LOST, 32'd0, "pu_lost_e14");
        pu[5]  = mkv(16,  S_TUS,  32'd0, "pu_tus_e16");
        pu[6]  = mkv(17,  S_TUS,  32'd1, "pu_tus_e17");
        pu[7]  = mkv(18,  S_TUS,  32'd0, "pu_tus_e18");
        pu[8]  = mkv(21,  S_TUS,  32'd1, "pu_tus_e21");
        pu[9]  = mkv(52,  S_TMS,  32'd0, "pu_tms_e52");
        pu[10] = mkv(53,  S_TMS,  32'd1, "pu_tms_e53");
        pu[11] = mkv(53,  S_UPT,  32'd1, "pu_uptime_e53");
        pu[12] = mkv(412, S_TS,   32'd0, "pu_ts_e412");
        pu[13] = mkv(413, S_TS,   32'd1, "pu_ts_e413");

        // Power-up and tick cascade.
        do_reset("reset1", t0);
        for (int i = 0; i < 14; i++) ex(t0 + pu[i].rel, pu[i].sig, pu[i].val, pu[i].name);
        goto_edge(t0 + 14);
        n_us = 0; n_ms = 0; n_s = 0; n_rdy_lo = 0; n_align = 0; last_us = 0;
        for (int i = 0; i < 4000; i++) begin
            @(posedge clk);
            #1;
            if (!ready) n_rdy_lo++;
            if (rst_out == ready) n_align++;
            if (tick_us) begin
                if (n_us > 0 && (i - last_us) != 4) n_align++;
                last_us = i;
                n_us++;
            end
            if (tick_ms) begin
                n_ms++;
                if (!tick_us || (n_us % 10) != 0 || uptime_ms != 32'(n_ms)) n_align++;
            end
            if (tick_s) begin
                n_s++;
                if (!tick_ms || (n_ms % 10) != 0) n_align++;
            end
        end
        chk("cascade_tick_us", 32'(n_us), 32'd1000);
        chk("cascade_tick_ms", 32'(n_ms), 32'd100);
        chk("cascade_tick_s",  32'(n_s),  32'd10);
        chk("cascade_uptime",  uptime_ms, 32'd100);
        chk("cascade_ready_low", 32'(n_rdy_lo), 32'd0);
        chk("cascade_alignment", 32'(n_align), 32'd0);

        // Lock glitch during FILTER, then lock loss in RUN at UPTIME_MS=5 and re-qualification.
        do_reset("reset2", t0);
        d = t0 + 220;
        r = d + 50;
        ex(t0 + 14, S_RDY,  32'd0, "glitch_ready_e14");
        ex(t0 + 17, S_RDY,  32'd0, "glitch_ready_e17");
        ex(t0 + 17, S_RST,  32'd1, "glitch_rst_e17");
        ex(t0 + 18, S_RDY,  32'd1, "glitch_ready_e18");
        ex(t0 + 18, S_RST,  32'd0, "glitch_rst_e18");
        ex(t0 + 18, S_LOST, 32'd0, "glitch_lost");
        ex(d + 1,   S_RDY,  32'd1, "loss_ready_d1");
        ex(d + 1,   S_LOST, 32'd0, "loss_lost_d1");
        ex(d + 1,   S_TUS,  32'd1, "loss_tus_d1");
        ex(d + 2,   S_RDY,  32'd0, "loss_ready_d2");
        ex(d + 2,   S_RST,  32'd1, "loss_rst_d2");
        ex(d + 2,   S_LOST, 32'd1, "loss_lost_d2");
        ex(d + 2,   S_UPT,  32'd5, "loss_uptime_d2");
        ex(d + 5,   S_TUS,  32'd0, "loss_ticks_stopped");
        ex(d + 40,  S_UPT,  32'd5, "loss_uptime_hold");
        ex(r + 13,  S_RDY,  32'd0, "relock_ready_r13");
        ex(r + 14,  S_RDY,  32'd1, "relock_ready_r14");
        ex(r + 14,  S_LOST, 32'd1, "relock_lost_sticky");
        ex(r + 16,  S_TUS,  32'd0, "relock_tus_r16");
        ex(r + 17,  S_TUS,  32'd1, "relock_tus_r17");
        ex(r + 52,  S_UPT,  32'd5, "relock_uptime_r52");
        ex(r + 52,  S_TMS,  32'd0, "relock_tms_r52");
        ex(r + 53,  S_TMS,  32'd1, "relock_tms_r53");
        ex(r + 53,  S_UPT,  32'd6, "relock_uptime_r53");
        goto_edge(t0 + 3); lock = 1'b0;
        goto_edge(t0 + 4); lock = 1'b1;
        goto_edge(d);      lock = 1'b0;
        goto_edge(r);      lock = 1'b1;

        // Plain LOCK_LOST clear.
        c = r + 60;
        ex(c - 1, S_LOST, 32'd1, "clr_lost_before");
        ex(c,     S_LOST, 32'd0, "clr_lost_after");
        goto_edge(c);     lock_lost_clr = 1'b1;
        goto_edge(c + 1); lock_lost_clr = 1'b0;

        // SOFT_RST together with lock loss: lock loss wins.
        d2 = r + 80;
        r2 = d2 + 10;
        ex(d2 - 1, S_LOST, 32'd0, "both_lost_before");
        ex(d2 - 1, S_RDY,  32'd1, "both_ready_before");
        ex(d2,     S_LOST, 32'd1, "both_lost_set");
        ex(d2,     S_RDY,  32'd0, "both_ready");
        ex(d2,     S_RST,  32'd1, "both_rst");
        ex(d2 + 1, S_LOST, 32'd1, "both_lost_hold");
        ex(r2 + 13, S_RDY, 32'd0, "both_relock_r13");
        ex(r2 + 14, S_RDY, 32'd1, "both_relock_r14");
        goto_edge(d2 - 2); lock = 1'b0;
        goto_edge(d2);     soft_rst = 1'b1;
        goto_edge(d2 + 1); soft_rst = 1'b0;
        goto_edge(r2);     lock = 1'b1;

        // SOFT_RST alone: exactly RST_STRETCH cycles of reset, tick phase restarts.
        e0 = r2 + 14;
        s  = e0 + 21;
        ex(s - 1,  S_RDY,  32'd1, "soft_ready_before");
        ex(s,      S_RDY,  32'd0, "soft_ready_s0");
        ex(s,      S_RST,  32'd1, "soft_rst_s0");
        ex(s + 7,  S_RST,  32'd1, "soft_rst_s7");
        ex(s + 7,  S_RDY,  32'd0, "soft_ready_s7");
        ex(s + 8,  S_RST,  32'd0, "soft_rst_s8");
        ex(s + 8,  S_RDY,  32'd1, "soft_ready_s8");
        ex(s + 8,  S_LOST, 32'd1, "soft_lost_untouched");
        ex(s + 10, S_TUS,  32'd0, "soft_tus_s10");
        ex(s + 11, S_TUS,  32'd1, "soft_tus_s11");
        goto_edge(s);     soft_rst = 1'b1;
        goto_edge(s + 1); soft_rst = 1'b0;

        // LOCK_LOST_CLR in the same cycle as a new loss: set wins.
        f = s + 40;
        ex(f - 9, S_LOST, 32'd0, "setclr_cleared");
        ex(f - 1, S_LOST, 32'd0, "setclr_before");
        ex(f - 1, S_RDY,  32'd1, "setclr_ready_before");
        ex(f,     S_LOST, 32'd1, "setclr_set_wins");
        ex(f,     S_RDY,  32'd0, "setclr_ready");
        ex(f + 1, S_LOST, 32'd1, "setclr_hold");
        goto_edge(f - 10); lock_lost_clr = 1'b1;
        goto_edge(f - 9);  lock_lost_clr = 1'b0;
        goto_edge(f - 2);  lock = 1'b0;
        goto_edge(f);      lock_lost_clr = 1'b1;
        goto_edge(f + 1);  lock_lost_clr = 1'b0;

        // UPTIME_MS wrap.
        g = f + 10;
        ex(g + 13, S_RDY, 32'd0,          "wrap_ready_g13");
        ex(g + 14, S_RDY, 32'd1,          "wrap_ready_g14");
        ex(g + 52, S_UPT, 32'hFFFF_FFFF,  "wrap_uptime_preload");
        ex(g + 52, S_TMS, 32'd0,          "wrap_tms_g52");
        ex(g + 53, S_TMS, 32'd1,          "wrap_tms_g53");
        ex(g + 53, S_TS,  32'd0,          "wrap_ts_g53");
        ex(g + 53, S_UPT, 32'd0,          "wrap_uptime_zero");
        ex(g + 54, S_UPT, 32'd0,          "wrap_uptime_hold");
        goto_edge(g); lock = 1'b1;
        goto_edge(g + 21);
        force dut.uptime_q = 32'hFFFF_FFFF;
        #2;
        release dut.uptime_q;

        goto_edge(g + 60);
        chk("scoreboard_drained", 32'(sb.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
